// File: rtl/boids_pkg.sv
// Shared definitions for the boid sprite plotter.
// Holds the plotter FSM state encoding, the default screen geometry and
// palette indices, and the coordinate typedefs used around the position RAM.
package boids_pkg;

    localparam int COORD_X_W  = 10;
    localparam int COORD_Y_W  = 9;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int BG_COLOR   = 31;
    localparam int BOID_COLOR = 42;

    typedef logic [COORD_X_W-1:0] coord_x_t;
    typedef logic [COORD_Y_W-1:0] coord_y_t;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        FETCH,
        LATCH,
        DRAW,
        DONE
    } plot_state_t;

endpackage

// File: rtl/boid_sprite_plotter_box_sweeper.sv
// box_sweeper: walks a BOX x BOX square (dy outer, dx inner) anchored at
// (base_x, base_y) and issues one framebuffer write per on-screen pixel.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           one-cycle launch; base_x/base_y/color are taken this cycle
//   base_x, base_y  top-left corner of the square
//   color           palette index written for every pixel of this sweep
//   fb_ready        framebuffer accepts the presented write this cycle
//   fb_wen/fb_addr/fb_data  registered framebuffer write request
//   done            one-cycle pulse in the cycle the sweep finishes
module box_sweeper #(
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 9,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BOX        = 3,
    parameter int PIX_ADDR_W = 19,
    parameter int COLOR_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [X_WIDTH-1:0]    base_x,
    input  logic [Y_WIDTH-1:0]    base_y,
    input  logic [COLOR_W-1:0]    color,
    input  logic                  fb_ready,
    output logic                  fb_wen,
    output logic [PIX_ADDR_W-1:0] fb_addr,
    output logic [COLOR_W-1:0]    fb_data,
    output logic                  done
);

    localparam int                    CNT_W      = 3;
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(BOX - 1);
    localparam logic [X_WIDTH:0]      X_LIMIT    = (X_WIDTH + 1)'(SCREEN_W);
    localparam logic [Y_WIDTH:0]      Y_LIMIT    = (Y_WIDTH + 1)'(SCREEN_H);
    localparam logic [PIX_ADDR_W-1:0] ROW_STRIDE = PIX_ADDR_W'(SCREEN_W);

    logic                  active_reg;
    logic                  pending_reg;
    logic [CNT_W-1:0]      dx_reg, dy_reg;
    logic [X_WIDTH-1:0]    bx_reg;
    logic [Y_WIDTH-1:0]    by_reg;
    logic [COLOR_W-1:0]    color_reg;
    logic                  fb_wen_reg;
    logic [PIX_ADDR_W-1:0] fb_addr_reg;
    logic [COLOR_W-1:0]    fb_data_reg;

    logic                  slot_free;
    logic                  issue;
    logic [CNT_W-1:0]      cur_dx, cur_dy, dx_next, dy_next;
    logic [X_WIDTH-1:0]    cur_bx;
    logic [Y_WIDTH-1:0]    cur_by;
    logic [COLOR_W-1:0]    cur_color;
    logic [X_WIDTH:0]      px;
    logic [Y_WIDTH:0]      py;
    logic                  in_bounds;
    logic                  last_pixel;
    logic [PIX_ADDR_W-1:0] px_ext, py_ext, pix_addr;
    logic [PIX_ADDR_W-1:0] row_term [PIX_ADDR_W];

    // The output register may take a new pixel when it is empty or its
    // current write is being accepted; otherwise everything holds.
    assign slot_free = !fb_wen_reg || fb_ready;
    assign issue     = start || active_reg;

    // On the start cycle the first pixel is generated straight from the
    // launch inputs so the first write is registered without a setup cycle.
    assign cur_dx    = start ? '0 : dx_reg;
    assign cur_dy    = start ? '0 : dy_reg;
    assign cur_bx    = start ? base_x : bx_reg;
    assign cur_by    = start ? base_y : by_reg;
    assign cur_color = start ? color : color_reg;

    // One extra bit on the sums: a square hanging off the right/bottom edge
    // is clipped, never wrapped.
    assign px = {1'b0, cur_bx} + (X_WIDTH + 1)'(cur_dx);
    assign py = {1'b0, cur_by} + (Y_WIDTH + 1)'(cur_dy);

    assign in_bounds  = (px < X_LIMIT) && (py < Y_LIMIT);
    assign last_pixel = (cur_dx == CNT_LAST) && (cur_dy == CNT_LAST);

    always_comb begin
        dx_next = cur_dx + CNT_W'(1);
        dy_next = cur_dy;
        if (cur_dx == CNT_LAST) begin
            dx_next = '0;
            dy_next = cur_dy + CNT_W'(1);
        end
    end

    // Row offset y*SCREEN_W as a sum of shifted copies of y, one per set
    // bit of the stride constant.
    assign px_ext = PIX_ADDR_W'(px);
    assign py_ext = PIX_ADDR_W'(py);

    for (genvar gi = 0; gi < PIX_ADDR_W; gi++) begin : g_row_term
        if (ROW_STRIDE[gi]) begin : g_set
            assign row_term[gi] = py_ext << gi;
        end else begin : g_clr
            assign row_term[gi] = '0;
        end
    end

    always_comb begin
        pix_addr = px_ext;
        for (int k = 0; k < PIX_ADDR_W; k++) begin
            pix_addr = pix_addr + row_term[k];
        end
    end

    // Finished once the last pixel has left the counters and the output
    // register is either empty (last pixel clipped) or being accepted.
    assign done = pending_reg && !active_reg && slot_free;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_reg  <= 1'b0;
            pending_reg <= 1'b0;
            dx_reg      <= '0;
            dy_reg      <= '0;
            bx_reg      <= '0;
            by_reg      <= '0;
            color_reg   <= '0;
            fb_wen_reg  <= 1'b0;
            fb_addr_reg <= '0;
            fb_data_reg <= '0;
        end else begin
            if (start) begin
                bx_reg    <= base_x;
                by_reg    <= base_y;
                color_reg <= color;
            end
            if (issue && slot_free) begin
                fb_wen_reg  <= in_bounds;
                fb_addr_reg <= pix_addr;
                fb_data_reg <= cur_color;
                active_reg  <= !last_pixel;
                dx_reg      <= dx_next;
                dy_reg      <= dy_next;
            end else if (slot_free) begin
                fb_wen_reg <= 1'b0;
            end
            if (start) begin
                pending_reg <= 1'b1;
            end else if (done) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign fb_wen  = fb_wen_reg;
    assign fb_addr = fb_addr_reg;
    assign fb_data = fb_data_reg;

endmodule

// File: rtl/boid_sprite_plotter.sv
// boid_sprite_plotter: per-frame framebuffer updater for the boids display.
// On frame_start it erases every square drawn last frame (from a shadow
// table of previous positions), then fetches each boid position from the
// position RAM and draws a BOX x BOX square in the boid colour.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   frame_start          one pulse per frame; ignored (and counted) while busy
//   boid_count           boids to draw, clamped to NUM_BOIDS
//   pos_addr/pos_x/pos_y position RAM read port (1-cycle read latency)
//   fb_wen/fb_ready/fb_addr/fb_data  framebuffer write port with back-pressure
//   busy, frame_done     frame in progress / one-cycle completion pulse
//   overrun_cnt          saturating count of ignored frame_start pulses
module boid_sprite_plotter #(
    parameter int NUM_BOIDS  = 16,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 9,
    parameter int SCREEN_W   = boids_pkg::SCREEN_W,
    parameter int SCREEN_H   = boids_pkg::SCREEN_H,
    parameter int BOX        = 3,
    parameter int PIX_ADDR_W = 19,
    parameter int COLOR_W    = 8,
    parameter int BG_COLOR   = boids_pkg::BG_COLOR,
    parameter int BOID_COLOR = boids_pkg::BOID_COLOR
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               frame_start,
    input  logic [$clog2(NUM_BOIDS+1)-1:0]     boid_count,
    output logic [$clog2(NUM_BOIDS)-1:0]       pos_addr,
    input  logic [X_WIDTH-1:0]                 pos_x,
    input  logic [Y_WIDTH-1:0]                 pos_y,
    output logic                               fb_wen,
    input  logic                               fb_ready,
    output logic [PIX_ADDR_W-1:0]              fb_addr,
    output logic [COLOR_W-1:0]                 fb_data,
    output logic                               busy,
    output logic                               frame_done,
    output logic [7:0]                         overrun_cnt
);

    import boids_pkg::*;

    localparam int AW = $clog2(NUM_BOIDS);
    localparam int CW = $clog2(NUM_BOIDS + 1);

    plot_state_t           state_reg, state_next;
    logic [CW-1:0]         idx_reg, idx_next, idx_inc;
    logic [CW-1:0]         n_reg, n_next;
    logic                  launched_reg, launched_next;
    logic [NUM_BOIDS-1:0]  valid_reg;
    logic [AW-1:0]         pos_addr_reg;
    logic [7:0]            overrun_reg;

    // Shadow of the positions drawn last frame; only the valid bits need reset.
    logic [X_WIDTH-1:0]    shadow_x_reg [NUM_BOIDS];
    logic [Y_WIDTH-1:0]    shadow_y_reg [NUM_BOIDS];

    logic [AW-1:0]         slot;
    logic                  valid_clear, valid_set;
    logic                  sw_start, sw_done;
    logic [COLOR_W-1:0]    sw_color;
    logic                  busy_int;

    assign slot     = idx_reg[AW-1:0];
    assign idx_inc  = idx_reg + CW'(1);
    assign busy_int = (state_reg != IDLE) && (state_reg != DONE);
    assign sw_color = (state_reg == DRAW) ? COLOR_W'(BOID_COLOR) : COLOR_W'(BG_COLOR);

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        n_next        = n_reg;
        launched_next = launched_reg;
        sw_start      = 1'b0;
        valid_clear   = 1'b0;
        valid_set     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    n_next        = (boid_count > CW'(NUM_BOIDS)) ? CW'(NUM_BOIDS) : boid_count;
                    idx_next      = '0;
                    launched_next = 1'b0;
                    state_next    = ERASE;
                end
            end
            ERASE: begin
                // launched_reg marks that the sweeper owns the current entry;
                // invalid entries cost a single cycle.
                if (idx_reg == CW'(NUM_BOIDS)) begin
                    valid_clear = 1'b1;
                    idx_next    = '0;
                    state_next  = (n_reg == '0) ? DONE : FETCH;
                end else if (!launched_reg) begin
                    if (valid_reg[slot]) begin
                        sw_start      = 1'b1;
                        launched_next = 1'b1;
                    end else begin
                        idx_next = idx_inc;
                    end
                end else if (sw_done) begin
                    launched_next = 1'b0;
                    idx_next      = idx_inc;
                end
            end
            FETCH: begin
                state_next = LATCH;
            end
            LATCH: begin
                valid_set  = 1'b1;
                state_next = DRAW;
            end
            DRAW: begin
                if (!launched_reg) begin
                    sw_start      = 1'b1;
                    launched_next = 1'b1;
                end else if (sw_done) begin
                    launched_next = 1'b0;
                    idx_next      = idx_inc;
                    state_next    = (idx_inc < n_reg) ? FETCH : DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            n_reg        <= '0;
            launched_reg <= 1'b0;
            valid_reg    <= '0;
            pos_addr_reg <= '0;
            overrun_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            n_reg        <= n_next;
            launched_reg <= launched_next;
            if (valid_clear) begin
                valid_reg <= '0;
            end else if (valid_set) begin
                valid_reg[slot] <= 1'b1;
            end
            // Address is registered on the way into FETCH so the RAM sees it
            // for the whole FETCH cycle and returns data during LATCH.
            if (state_next == FETCH && state_reg != FETCH) begin
                pos_addr_reg <= idx_next[AW-1:0];
            end
            if (frame_start && busy_int && overrun_reg != 8'hFF) begin
                overrun_reg <= overrun_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (valid_set) begin
            shadow_x_reg[slot] <= pos_x;
            shadow_y_reg[slot] <= pos_y;
        end
    end

    box_sweeper #(
        .X_WIDTH    (X_WIDTH),
        .Y_WIDTH    (Y_WIDTH),
        .SCREEN_W   (SCREEN_W),
        .SCREEN_H   (SCREEN_H),
        .BOX        (BOX),
        .PIX_ADDR_W (PIX_ADDR_W),
        .COLOR_W    (COLOR_W)
    ) u_sweeper (
        .clk      (clk),
        .reset    (reset),
        .start    (sw_start),
        .base_x   (shadow_x_reg[slot]),
        .base_y   (shadow_y_reg[slot]),
        .color    (sw_color),
        .fb_ready (fb_ready),
        .fb_wen   (fb_wen),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .done     (sw_done)
    );

    assign pos_addr    = pos_addr_reg;
    assign busy        = busy_int;
    assign frame_done  = (state_reg == DONE);
    assign overrun_cnt = overrun_reg;

endmodule

// File: tb/tb_boid_sprite_plotter.sv
// Self-checking bench for boid_sprite_plotter: drives frames with directed
// and random boid positions and fb_ready patterns, records every accepted
// framebuffer write, and compares against a frame-level reference model.
module tb_boid_sprite_plotter;

    localparam int NB      = 16;
    localparam int SW      = 640;
    localparam int SH      = 480;
    localparam int BOXSZ   = 3;
    localparam int BG      = 31;
    localparam int FG      = 42;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic [4:0]  boid_count;
    logic [3:0]  pos_addr;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic        fb_wen;
    logic        fb_ready;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overrun_cnt;

    boid_sprite_plotter dut (
        .clk         (clk),
        .reset       (rst_n),
        .frame_start (frame_start),
        .boid_count  (boid_count),
        .pos_addr    (pos_addr),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .fb_wen      (fb_wen),
        .fb_ready    (fb_ready),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun_cnt (overrun_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] mem_x [NB];
    logic [8:0] mem_y [NB];

    // Reference model state: squares currently on screen.
    bit         prev_v [NB];
    int         prev_x [NB];
    int         prev_y [NB];

    wr_t        exp_q [$];
    wr_t        got_q [$];
    int         ready_mode = 0;
    int         done_pulses = 0;
    bit         held_v = 0;
    int         held_addr, held_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Position RAM: one-cycle registered read.
    always @(posedge clk) begin
        pos_x <= mem_x[pos_addr];
        pos_y <= mem_y[pos_addr];
    end

    // fb_ready pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       fb_ready = 1'b1;
            1:       fb_ready = ~fb_ready;
            2:       fb_ready = 1'($urandom_range(0, 1));
            default: fb_ready = 1'b0;
        endcase
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check_eq("hold_wen", fb_wen, 1);
                check_eq("hold_addr", fb_addr, held_addr);
                check_eq("hold_data", fb_data, held_data);
            end
            if (fb_wen && fb_ready) begin
                got_q.push_back('{addr: int'(fb_addr), data: int'(fb_data)});
            end
            held_v    = fb_wen && !fb_ready;
            held_addr = int'(fb_addr);
            held_data = int'(fb_data);
            if (frame_done) begin
                done_pulses++;
                check_eq("busy_in_done", busy, 0);
            end
        end
    end

    function automatic void add_box(input int bx, input int by, input int color);
        for (int dy = 0; dy < BOXSZ; dy++) begin
            for (int dx = 0; dx < BOXSZ; dx++) begin
                if (bx + dx < SW && by + dy < SH) begin
                    exp_q.push_back('{addr: (bx + dx) + SW * (by + dy), data: color});
                end
            end
        end
    endfunction

    // Expected write list for one frame, then the new on-screen state.
    function automatic void model_frame(input int count);
        int n;
        n = (count > NB) ? NB : count;
        exp_q.delete();
        for (int i = 0; i < NB; i++) begin
            if (prev_v[i]) add_box(prev_x[i], prev_y[i], BG);
        end
        for (int i = 0; i < n; i++) begin
            add_box(int'(mem_x[i]), int'(mem_y[i]), FG);
        end
        for (int i = 0; i < NB; i++) begin
            prev_v[i] = (i < n);
            prev_x[i] = int'(mem_x[i]);
            prev_y[i] = int'(mem_y[i]);
        end
    endfunction

    function automatic int count_color(input int color);
        int c = 0;
        foreach (got_q[k]) if (got_q[k].data == color) c++;
        return c;
    endfunction

    task automatic run_frame(input int count, input int extra_pulses);
        bit seen = 0;
        model_frame(count);
        got_q.delete();
        done_pulses = 0;
        @(posedge clk); #1;
        boid_count  = 5'(count);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int p = 0; p < extra_pulses; p++) begin
            @(posedge clk); #1 frame_start = 1'b1;
            @(posedge clk); #1 frame_start = 1'b0;
        end
        if (extra_pulses > 250) check_eq("overrun_sat", overrun_cnt, 255);
        if (ready_mode == 3) ready_mode = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        check_eq("frame_done_seen", seen, 1);
        repeat (2) @(negedge clk);
        check_eq("done_pulses", done_pulses, 1);
        check_eq("busy_after", busy, 0);
        check_eq("wr_count", got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            check_eq("wr_addr", got_q[k].addr, exp_q[k].addr);
            check_eq("wr_data", got_q[k].data, exp_q[k].data);
        end
        $display("frame count=%0d mode=%0d writes=%0d expected=%0d overrun=%0d",
                 count, ready_mode, got_q.size(), exp_q.size(), overrun_cnt);
    endtask

    initial begin
        bit hit;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        boid_count  = '0;
        fb_ready    = 1'b1;
        for (int i = 0; i < NB; i++) begin
            mem_x[i]  = '0;
            mem_y[i]  = '0;
            prev_v[i] = 0;
            prev_x[i] = 0;
            prev_y[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_fb_wen", fb_wen, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_overrun", overrun_cnt, 0);
        check_eq("rst_pos_addr", pos_addr, 0);
        check_eq("rst_fb_addr", fb_addr, 0);
        check_eq("rst_fb_data", fb_data, 0);
        rst_n = 1'b1;

        // First frame: nothing to erase, one box at (10,20).
        mem_x[0] = 10'd10; mem_y[0] = 9'd20;
        run_frame(1, 0);
        if (got_q.size() > 0) check_eq("f1_first_addr", got_q[0].addr, 12810);
        check_eq("f1_bg_writes", count_color(BG), 0);

        // Move by one pixel: erase old square, draw new one.
        mem_x[0] = 10'd11;
        run_frame(1, 0);
        check_eq("f2_bg_writes", count_color(BG), 9);

        // Bottom-right corner: clipped to 4 pixels.
        mem_x[0] = 10'd638; mem_y[0] = 9'd478;
        run_frame(1, 0);
        check_eq("f3_fg_writes", count_color(FG), 4);

        // Back-pressure toggling every cycle.
        ready_mode = 1;
        mem_x[0] = 10'd100; mem_y[0] = 9'd100;
        run_frame(1, 0);
        ready_mode = 0;

        // Three ignored pulses while busy.
        mem_x[0] = 10'd200; mem_y[0] = 9'd50;
        run_frame(1, 3);
        check_eq("overrun_3", overrun_cnt, 3);

        // Stall the framebuffer and flood frame_start to saturate the counter.
        ready_mode = 3;
        mem_x[1] = 10'd300; mem_y[1] = 9'd200;
        run_frame(2, 300);
        check_eq("overrun_hold", overrun_cnt, 255);

        // Random frames, including clamped counts and edge positions.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NB; i++) begin
                mem_x[i] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(630, 700)) : 10'($urandom_range(0, 640));
                mem_y[i] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(470, 511)) : 9'($urandom_range(0, 480));
            end
            ready_mode = $urandom_range(0, 2);
            run_frame($urandom_range(0, 20), 0);
        end
        ready_mode = 0;

        // Reset in the middle of DRAW.
        ready_mode = 1;
        mem_x[0] = 10'd50; mem_y[0] = 9'd60;
        mem_x[1] = 10'd70; mem_y[1] = 9'd80;
        @(posedge clk); #1;
        boid_count  = 5'd2;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        hit = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (fb_wen && fb_data == 8'(FG)) begin
                hit = 1;
                break;
            end
        end
        check_eq("draw_reached", hit, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_fb_wen", fb_wen, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_overrun", overrun_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        for (int i = 0; i < NB; i++) prev_v[i] = 0;
        run_frame(1, 0);
        check_eq("postrst_bg_writes", count_color(BG), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/boid_sprite_plotter.md
Name: boid_sprite_plotter

Overview:
Per-frame framebuffer updater for the boids display. On each frame-start pulse it erases every boid's previously drawn square to the background colour, then reads each boid's new position from the position RAM and draws a BOX x BOX square in the boid colour. It replaces per-pixel boid comparison in the VGA path, scales to NUM_BOIDS, and sits between the boid position RAM and the framebuffer write port.

Parameters:
NUM_BOIDS, 16, maximum boids held in the shadow table; sets the width of pos_addr and boid_count.
X_WIDTH, 10, x coordinate width.
Y_WIDTH, 9, y coordinate width.
SCREEN_W, 640, visible width in pixels.
SCREEN_H, 480, visible height in pixels.
BOX, 3, square side in pixels, 1..8.
PIX_ADDR_W, 19, framebuffer address width.
COLOR_W, 8, palette index width.
BG_COLOR, 31, palette index written when erasing.
BOID_COLOR, 42, palette index written when drawing.

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
frame_start  in  1  single-cycle pulse in the clk domain, one per frame
boid_count  in  $clog2(NUM_BOIDS+1)  boids to draw, sampled at frame_start; values above NUM_BOIDS are clamped
pos_addr  out  $clog2(NUM_BOIDS)  position RAM read address
pos_x  in  X_WIDTH  position RAM data; valid exactly 1 cycle after pos_addr is driven
pos_y  in  Y_WIDTH  position RAM data, same timing as pos_x
fb_wen  out  1  framebuffer write request
fb_ready  in  1  framebuffer accepts the write this cycle
fb_addr  out  PIX_ADDR_W  pixel address, x + SCREEN_W*y
fb_data  out  COLOR_W  palette index
busy  out  1  high from the frame_start accept until the cycle frame_done is asserted
frame_done  out  1  one-cycle pulse when the frame update completes
overrun_cnt  out  8  saturating count of frame_start pulses ignored while busy

Behaviour:
- Reset (reset = 0, asynchronous): FSM goes to IDLE. fb_wen, busy, frame_done = 0. overrun_cnt = 0. pos_addr = 0, fb_addr = 0, fb_data = 0. All shadow valid bits = 0. Reset mid-frame abandons the frame; no further writes are issued.
- IDLE: on frame_start, latch n = min(boid_count, NUM_BOIDS), set busy, go to ERASE with boid index i = 0.
- ERASE: for each i < NUM_BOIDS whose shadow entry is valid, sweep dy = 0..BOX-1 (outer loop) and dx = 0..BOX-1 (inner loop). Each pixel is written with BG_COLOR at (sx+dx, sy+dy). Entries that are not valid are skipped in 1 cycle. When done, clear all valid bits and go to FETCH with i = 0. If n = 0, go straight to DONE after ERASE.
- FETCH: drive pos_addr = i for 1 cycle. LATCH (next cycle): capture pos_x and pos_y into shadow[i], set valid[i], go to DRAW.
- DRAW: same sweep as ERASE, writing BOID_COLOR. Then i++. If i < n go to FETCH, otherwise go to DONE.
- DONE: frame_done = 1 for 1 cycle, busy drops in the same cycle, return to IDLE.
- Write handshake: a write completes in a cycle where fb_wen && fb_ready. While fb_ready = 0, fb_addr, fb_data and fb_wen are held stable and the sweep counters do not advance.
- Clipping: if sx+dx >= SCREEN_W or sy+dy >= SCREEN_H, no write is issued (fb_wen = 0) and the counters advance in that cycle. Sums are computed with 1 extra bit so there is no wrap-around. Clipping is not partial: such a pixel is always skipped, never wrapped.
- Address: fb_addr = x + SCREEN_W*y, computed at PIX_ADDR_W width; the constant multiply is computed as a shift-add.
- Timing: fb_wen is registered; the first write appears 1 cycle after entering ERASE or DRAW. With fb_ready held at 1, one pixel completes per cycle.
- Overrun: frame_start while busy = 1 is ignored and overrun_cnt increments, saturating at 255. frame_start in the DONE cycle is also ignored.
- Overlapping boids: writes happen in index order, so the last writer wins. Erasing before drawing means no stale pixels remain.

Decomposition:
- Shared package boids_pkg holds: the FSM state enum (IDLE, ERASE, FETCH, LATCH, DRAW, DONE), SCREEN_W, SCREEN_H, BG_COLOR, BOID_COLOR, and the coordinate typedefs.
- One sub-module, box_sweeper: dx/dy counters with BOX wrap, clip test, address generation, and fb_ready stall. It is reused by ERASE and DRAW with a colour select.

Test Plan:
- Reset, then frame_start with boid_count = 1 and position (10,20), BOX = 3, fb_ready = 1 → no erase writes; 9 BOID_COLOR writes at addresses 12810..12812, 13450..13452 and 14090..14092; frame_done pulses and busy drops.
- Second frame with position (11,20) → 9 BG_COLOR writes at the previous addresses, then 9 BOID_COLOR writes starting at 12811.
- Boid at (638,478) → only 4 writes (addresses 306558, 306559, 307198, 307199); no wrapped addresses appear.
- fb_ready toggled 0/1 every cycle during DRAW → each address is held until accepted; all 9 writes occur with no duplicates and no drops.
- frame_start pulsed 3 times while busy → overrun_cnt = 3 and the frame output is unchanged; 300 ignored pulses → overrun_cnt saturates at 255.
- reset asserted in the middle of DRAW → fb_wen = 0 immediately; the next frame performs no erase because all valid bits are cleared.
